// File: rtl/rom_arbiter.sv
// Arbitrates the instruction-ROM port between IF-stage fetch and the program loader.
// Optional performance counters are enabled with `define ROM_ARB_PERF_EN.
module rom_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side (PC block / ID)
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rdata_valid,
  output logic              stall_pc,
  // loader side
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [SEL_W-1:0]  ld_sel,
  output logic              ld_ack,
  // ROM macro side
  output logic [ADDR_W-1:0] rom_addr,
  output logic [SEL_W-1:0]  rom_write_en,
  output logic [DATA_W-1:0] rom_write_data,
  input  logic [DATA_W-1:0] rom_rdata,
  // performance counters
  output logic [31:0]       perf_ld_beats,
  output logic [31:0]       perf_stall_cyc
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_LOAD,
    S_YIELD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             in_load;

  // Reset overrides the registered state so a beat presented in the reset cycle is dropped.
  assign in_load  = (state == S_LOAD) && !rst;
  assign stall_pc = in_load;
  assign ld_ack   = in_load && ld_req;
  assign if_rdata = rom_rdata;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rom_addr       = if_addr;
    rom_write_en   = '0;
    rom_write_data = '0;
    if (state == S_LOAD) begin
      rom_addr       = ld_addr;
      rom_write_data = ld_wdata;
      if (ld_ack) rom_write_en = ld_sel;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_FETCH;
      burst_cnt      <= '0;
      if_rdata_valid <= 1'b0;
    end else begin
      if_rdata_valid <= (state != S_LOAD);
      case (state)
        S_FETCH: begin
          burst_cnt <= '0;
          if (ld_req) state <= S_LOAD;
        end
        S_LOAD: begin
          if (!ld_req) begin
            state     <= S_FETCH;
            burst_cnt <= '0;
          end else if (burst_cnt == BURST_LAST) begin
            // Burst cap reached: force one fetch slot so the PC cannot starve.
            state     <= S_YIELD;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        S_YIELD: begin
          burst_cnt <= '0;
          state     <= ld_req ? S_LOAD : S_FETCH;
        end
        default: begin
          state     <= S_FETCH;
          burst_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ROM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_beats  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (ld_ack)   perf_ld_beats  <= perf_ld_beats + 32'd1;
      if (stall_pc) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`else
  assign perf_ld_beats  = '0;
  assign perf_stall_cyc = '0;
`endif

  a_burst_cnt_cap : assert property (@(posedge clk) disable iff (rst) burst_cnt <= BURST_LAST);

endmodule
